// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch and load/store) onto one memory port.
// Round-robin grant, one access outstanding, and a bounded wait that aborts with err.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef struct packed {
    state_t      state;
    logic        last_d;
    logic [7:0]  cnt;
    logic        i_ack;
    logic        d_ack;
    logic        err;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } regs_t;

  // Timeout fires on the edge where the wait count would reach TIMEOUT.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  regs_t r_q;
  regs_t w_d;
  logic  w_i_elig;
  logic  w_d_elig;
  logic  w_grant_d;
  logic  w_done;

  // A requester whose ack is on the wire is about to drop its request.
  assign w_i_elig  = i_req && !r_q.i_ack;
  assign w_d_elig  = d_req && !r_q.d_ack;
  assign w_grant_d = w_d_elig && (!w_i_elig || !r_q.last_d);
  assign w_done    = mem_ready || (r_q.cnt == LP_CNT_LAST);

  always_comb begin
    // NOTE: w_d gets a full default first, so no branch can leave a field unassigned and infer a latch.
    w_d       = r_q;
    w_d.i_ack = 1'b0;
    w_d.d_ack = 1'b0;
    w_d.err   = 1'b0;
    unique case (r_q.state)
      IDLE: begin
        if (w_grant_d) begin
          w_d.state     = BUSY_D;
          w_d.last_d    = 1'b1;
          w_d.cnt       = '0;
          w_d.mem_req   = 1'b1;
          w_d.mem_we    = d_we;
          w_d.mem_be    = d_be;
          w_d.mem_addr  = d_addr;
          w_d.mem_wdata = d_wdata;
        end else if (w_i_elig) begin
          w_d.state     = BUSY_I;
          w_d.last_d    = 1'b0;
          w_d.cnt       = '0;
          w_d.mem_req   = 1'b1;
          w_d.mem_we    = 1'b0;
          w_d.mem_be    = 4'hF;
          w_d.mem_addr  = i_addr;
          w_d.mem_wdata = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_done) begin
          w_d.state   = IDLE;
          w_d.mem_req = 1'b0;
          w_d.err     = !mem_ready;
          if (r_q.state == BUSY_I) begin
            w_d.i_ack   = 1'b1;
            w_d.i_rdata = mem_ready ? mem_rdata : '0;
          end else begin
            w_d.d_ack   = 1'b1;
            w_d.d_rdata = (mem_ready && !r_q.mem_we) ? mem_rdata : '0;
          end
        end else begin
          w_d.cnt = r_q.cnt + 8'd1;
        end
      end
      default: w_d.state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (rst) r_q <= '0;
    else     r_q <= w_d;
  end

  assign i_ack     = r_q.i_ack;
  assign i_rdata   = r_q.i_rdata;
  assign d_ack     = r_q.d_ack;
  assign d_rdata   = r_q.d_rdata;
  assign err       = r_q.err;
  assign mem_req   = r_q.mem_req;
  assign mem_we    = r_q.mem_we;
  assign mem_be    = r_q.mem_be;
  assign mem_addr  = r_q.mem_addr;
  assign mem_wdata = r_q.mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory port and how long it has waited.
  typedef enum int {M_NONE, M_I, M_D} owner_t;
  owner_t      m_owner = M_NONE;
  bit          m_last_d = 1'b0;
  int          m_wait = 0;
  bit          m_iack = 1'b0, m_dack = 1'b0, m_err = 1'b0, m_req = 1'b0, m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;

  task automatic model_step();
    bit ie, de, ok, tmo;
    ie = i_req && !m_iack;
    de = d_req && !m_dack;
    m_iack = 1'b0; m_dack = 1'b0; m_err = 1'b0;
    if (rst) begin
      m_owner = M_NONE; m_last_d = 1'b0; m_wait = 0; m_req = 1'b0; m_we = 1'b0;
      m_be = '0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
      return;
    end
    if (m_owner == M_NONE) begin
      if (de && (!ie || !m_last_d)) begin
        m_owner = M_D; m_last_d = 1'b1; m_wait = 0; m_req = 1'b1;
        m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
      end else if (ie) begin
        m_owner = M_I; m_last_d = 1'b0; m_wait = 0; m_req = 1'b1;
        m_we = 1'b0; m_be = 4'hF; m_addr = i_addr; m_wdata = '0;
      end
    end else begin
      ok  = mem_ready;
      tmo = 1'b0;
      if (!ok) begin
        m_wait++;
        tmo = (m_wait == int'(TO));
      end
      if (ok || tmo) begin
        if (m_owner == M_I) begin
          m_iack = 1'b1; m_irdata = ok ? mem_rdata : 32'h0;
        end else begin
          m_dack = 1'b1; m_drdata = (ok && !m_we) ? mem_rdata : 32'h0;
        end
        m_err = tmo; m_req = 1'b0; m_owner = M_NONE;
      end
    end
  endtask

  // Memory responder and random-traffic controls
  int          mem_delay = 0;
  int          mem_age = 0;
  bit          rand_delay = 1'b0;
  bit          spur_en = 1'b0;
  bit          fix_rdata_en = 1'b0;
  logic [31:0] fix_rdata = '0;
  bit          rand_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("i_ack", i_ack, m_iack);
    check("d_ack", d_ack, m_dack);
    check("err", err, m_err);
    check("mem_req", mem_req, m_req);
    check("ack_excl", i_ack && d_ack, 1'b0);
    if (m_req) check("mem_cmd", {mem_we, mem_be, mem_addr, mem_wdata}, {m_we, m_be, m_addr, m_wdata});
    if (m_iack) check("i_rdata", i_rdata, m_irdata);
    if (m_dack) check("d_rdata", d_rdata, m_drdata);
    if (mem_req) begin
      mem_ready = (mem_age == mem_delay);
      mem_age++;
    end else begin
      mem_age = 0;
      if (rand_delay) mem_delay = $urandom_range(0, TO + 1);
      mem_ready = spur_en && ($urandom_range(0, 1) == 0 || !rand_mode);
    end
    mem_rdata = fix_rdata_en ? fix_rdata : $urandom;
    if (rand_mode) begin
      if (i_ack) begin
        i_req = $urandom_range(0, 1) == 1; i_addr = $urandom;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (d_ack) begin
        d_req = $urandom_range(0, 1) == 1;
        d_we = $urandom_range(0, 1) == 1; d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = $urandom_range(0, 1) == 1; d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {i_ack, d_ack, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check({tag, "_b"}, {i_rdata, d_rdata}, '0);
  endtask

  initial begin
    int k, gcnt, acnt, last_t, t_grant;
    bit seen;
    bit       g_we[4];
    logic [3:0] g_be[4];

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single fetch, two wait cycles
    mem_delay = 2; fix_rdata_en = 1'b1; fix_rdata = 32'h8C08_0004;
    i_req = 1'b1; i_addr = 32'h0040_0000;
    tick();
    check("fetch_grant", mem_req, 1'b1);
    check("fetch_addr", mem_addr, 32'h0040_0000);
    seen = 1'b0; k = 1;
    while (!seen && k < 12) begin
      tick(); k++;
      if (i_ack) seen = 1'b1;
    end
    check("fetch_ack_seen", seen, 1'b1);
    check("fetch_latency", k, 4);
    check("fetch_rdata", i_rdata, 32'h8C08_0004);
    check("fetch_err", err, 1'b0);
    i_req = 1'b0;
    fix_rdata_en = 1'b0;
    tick();

    // Simultaneous requests: D first, then alternate
    do_reset();
    mem_delay = 0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1000_0040; d_wdata = 32'h1234_ABCD;
    i_req = 1'b1; i_addr = 32'h0040_0010;
    gcnt = 0; k = 0;
    while (gcnt < 4 && k < 20) begin
      tick(); k++;
      if (mem_req && mem_age == 1) begin
        g_we[gcnt] = mem_we; g_be[gcnt] = mem_be; gcnt++;
      end
    end
    check("rr_grants", gcnt, 4);
    check("rr_g0_we", g_we[0], 1'b1);
    check("rr_g0_be", g_be[0], 4'b0011);
    check("rr_g1_we", g_we[1], 1'b0);
    check("rr_g1_be", g_be[1], 4'hF);
    check("rr_g2_we", g_we[2], 1'b1);
    check("rr_g3_we", g_we[3], 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();

    // Load that times out
    do_reset();
    mem_delay = 1000;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000_0000;
    tick();
    check("tmo_grant", mem_req, 1'b1);
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      tick(); k++;
      if (d_ack) seen = 1'b1;
    end
    check("tmo_ack_seen", seen, 1'b1);
    check("tmo_latency", k, int'(TO));
    check("tmo_err", err, 1'b1);
    check("tmo_rdata", d_rdata, 32'h0);
    check("tmo_memreq_drop", mem_req, 1'b0);
    d_req = 1'b0;
    tick();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0008;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    check("midrst_regrant", mem_req, 1'b1);
    check("midrst_addr", mem_addr, 32'h3000_0008);
    for (int j = 0; j < 6; j++) tick();
    d_req = 1'b0;
    tick();

    // Spurious mem_ready while idle, then zero-wait continuous fetch
    do_reset();
    spur_en = 1'b1; mem_delay = 0;
    for (int j = 0; j < 4; j++) tick();
    check("spur_no_ack", {i_ack, d_ack, mem_req}, 3'b000);
    i_req = 1'b1; i_addr = 32'h0040_0100;
    acnt = 0; last_t = -1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (i_ack) begin
        if (last_t >= 0) check("stream_spacing", j - last_t, 3);
        last_t = j; acnt++;
      end
    end
    check("stream_acks", acnt, 10);
    i_req = 1'b0; spur_en = 1'b0;
    tick(); tick();

    // Randomized traffic
    do_reset();
    rand_mode = 1'b1; rand_delay = 1'b1; spur_en = 1'b1;
    for (int j = 0; j < 3000; j++) tick();
    rand_mode = 1'b0;
    t_grant = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles a granted access waits for mem_ready before abort (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 Port: i_addr  input  32  fetch address, stable while i_req=1.
REQ-006 Port: i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 Port: i_rdata  output  32  fetched word, valid when i_ack=1.
REQ-008 Port: d_req  input  1  load/store request, held until d_ack.
REQ-009 Port: d_we  input  1  1=store, 0=load, stable while d_req=1.
REQ-010 Port: d_be  input  4  store byte enables.
REQ-011 Port: d_addr  input  32  data address.
REQ-012 Port: d_wdata  input  32  store data.
REQ-013 Port: d_ack  output  1  one-cycle data completion pulse.
REQ-014 Port: d_rdata  output  32  load word, valid when d_ack=1.
REQ-015 Port: err  output  1  timeout flag, valid with i_ack or d_ack.
REQ-016 Port: mem_req  output  1  memory access strobe, held until mem_ready.
REQ-017 Port: mem_we, mem_be, mem_addr, mem_wdata  output  1/4/32/32  memory command, registered.
REQ-018 Port: mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-019 Port: mem_ready  input  1  memory completion, sampled only while mem_req=1.

Function
REQ-020 FSM states SHALL be IDLE, BUSY_I, BUSY_D; all outputs SHALL be registered.
REQ-021 In IDLE with exactly one eligible request, SHALL enter BUSY_x next edge, latch that requester's command onto mem_* and assert mem_req (one cycle grant latency).
REQ-022 With both eligible, SHALL grant round-robin via flag last_d: grant D if last_d=0, else I; last_d updates on every grant (D->1, I->0).
REQ-023 A request SHALL be ineligible in the cycle its own ack is high (prevents regrant of a request being dropped).
REQ-024 For I grants mem_we=0, mem_be=4'hF, mem_wdata=0; for D grants mem_we/mem_be/mem_wdata copy d_we/d_be/d_wdata.
REQ-025 mem_* command SHALL remain constant while in BUSY_x.
REQ-026 In BUSY_x with mem_ready=1: next edge x_ack=1 for one cycle, x_rdata=mem_rdata (0 for stores), err=0, mem_req=0, state IDLE.
REQ-027 Wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready=0; when it reaches TIMEOUT, next edge x_ack=1, err=1, x_rdata=0, mem_req=0, state IDLE.
REQ-028 mem_ready in the same cycle as the count reaching TIMEOUT SHALL win (normal completion, err=0).
REQ-029 i_ack and d_ack SHALL never be high in the same cycle; at most one access outstanding.
REQ-030 mem_ready while mem_req=0 SHALL be ignored.
REQ-031 Minimum back-to-back throughput: IDLE->BUSY->ack->IDLE, i.e. one access per 3 cycles with zero-wait memory.

Reset
REQ-032 rst=1 at a clock edge SHALL force state IDLE, last_d=0, counter=0, and i_ack, d_ack, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_rdata, d_rdata all 0.
REQ-033 rst during BUSY_x SHALL abandon the access with no ack generated; after rst falls, pending requests re-arbitrate from IDLE with D first.

Verification
REQ-034 i_req=1, i_addr=0x00400000, mem_ready after 2 wait cycles, mem_rdata=0x8C080004 -> mem_req 1 cycle after i_req, mem_addr=0x00400000, i_ack pulse with i_rdata=0x8C080004, err=0.
REQ-035 i_req and d_req rise together after reset, d_we=1, d_be=4'b0011, d_wdata=0x1234ABCD -> D granted first (mem_we=1, mem_be=0011), then I; held requests alternate D,I,D,I.
REQ-036 d_req load, mem_ready never asserted, TIMEOUT=4 -> d_ack with err=1, d_rdata=0 exactly 4 BUSY cycles after grant; mem_req drops same edge.
REQ-037 rst pulsed 1 cycle mid-BUSY_D -> all outputs 0 next edge, no d_ack; held d_req regranted from IDLE after rst low.
REQ-038 mem_ready pulsed while IDLE, and zero-wait memory with continuous i_req -> no spurious ack; i_ack every 3rd cycle, acks never overlap.
